alu_arbiter_ctrl: RTL and testbench

ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_arbiter_ctrl_if.sv | 58 +++++
 rtl/rr_arb2.sv | 41 ++++
 rtl/alu_arbiter_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-port ALU arbiter controller: function codes,
// flag bit positions and controller states.
package alu_ctrl_pkg;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_MUL = 4'b0010;
    localparam logic [3:0] FN_DIV = 4'b0011;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic fn_legal(input logic [3:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_MUL, FN_DIV};
    endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter_ctrl.
// slave is the controller's view, master the environment's view.
interface alu_arbiter_ctrl_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [3:0]  req0_fn;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [3:0]  req1_fn;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_fn;
    logic [15:0] alu_d_out;
    logic        alu_z;
    logic        alu_c;
    logic        alu_n;
    logic        alu_v;

    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fn,
        input  req1_valid, req1_a, req1_b, req1_fn,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_err,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_fn,
        input  alu_d_out, alu_z, alu_c, alu_n, alu_v,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fn,
        output req1_valid, req1_a, req1_b, req1_fn,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_err,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_fn,
        output alu_d_out, alu_z, alu_c, alu_n, alu_v,
        input  busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter. Grant is combinational; the pointer flips to
// the other port after every grant so back-to-back contention alternates.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // ptr_q == 1 favours port 1, so granting port 0 hands priority to port 1
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o != 2'b00) begin
            ptr_d = gnt_o[0];
        end
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU, one operation
// at a time, and returns the result to the granted requester.
//
//   state   | meaning
//   IDLE    | waiting; grant one valid requester and latch its operation
//   EXEC    | latched operands on the ALU for one cycle, result captured
//   RESP    | result held for the granted port until it is consumed
module alu_arbiter_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_ctrl_if.slave bus
);

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  gnt;
    logic        rsp_hs;
    logic        port_q;
    logic [15:0] alu_a_q;
    logic [15:0] alu_b_q;
    logic [3:0]  alu_fn_q;
    logic [15:0] rsp_data_q;
    logic [3:0]  rsp_flags_q;
    logic        rsp_err_q;
    logic [3:0]  alu_flags;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_IDLE),
        .req_i ({bus.req1_valid, bus.req0_valid}),
        .gnt_o (gnt)
    );

    assign rsp_hs = (state_q == ST_RESP) && (port_q ? bus.rsp1_ready : bus.rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (gnt != 2'b00) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.busy       = (state_q != ST_IDLE);
        if (state_q == ST_IDLE) begin
            bus.req0_ready = gnt[0];
            bus.req1_ready = gnt[1];
        end
        if (state_q == ST_RESP) begin
            bus.rsp0_valid = !port_q;
            bus.rsp1_valid = port_q;
        end
    end

    always_comb begin
        alu_flags         = 4'b0000;
        alu_flags[FLAG_Z] = bus.alu_z;
        alu_flags[FLAG_C] = bus.alu_c;
        alu_flags[FLAG_N] = bus.alu_n;
        alu_flags[FLAG_V] = bus.alu_v;
    end

    // The operand registers double as the ALU drive, so they hold between grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q      <= 1'b0;
            alu_a_q     <= 16'h0000;
            alu_b_q     <= 16'h0000;
            alu_fn_q    <= 4'b0000;
            rsp_data_q  <= 16'h0000;
            rsp_flags_q <= 4'b0000;
            rsp_err_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && (gnt != 2'b00)) begin
                port_q   <= gnt[1];
                alu_a_q  <= gnt[1] ? bus.req1_a  : bus.req0_a;
                alu_b_q  <= gnt[1] ? bus.req1_b  : bus.req0_b;
                alu_fn_q <= gnt[1] ? bus.req1_fn : bus.req0_fn;
            end
            if (state_q == ST_EXEC) begin
                if (!fn_legal(alu_fn_q)) begin
                    rsp_data_q  <= 16'h0000;
                    rsp_flags_q <= 4'b0000;
                    rsp_err_q   <= 1'b1;
                end else if ((alu_fn_q == FN_DIV) && (alu_b_q == 16'h0000)) begin
                    rsp_data_q  <= 16'hFFFF;
                    rsp_flags_q <= 4'b0000;
                    rsp_err_q   <= 1'b1;
                end else begin
                    rsp_data_q  <= bus.alu_d_out;
                    rsp_flags_q <= alu_flags;
                    rsp_err_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_fn    = alu_fn_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Scoreboard bench for alu_arbiter_ctrl: per-port expected-result queues filled
// at issue time, popped by an independent monitor on each response handshake.
module tb_alu_arbiter_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [15:0] d;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } alu_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_a [2];
    logic [15:0] req_b [2];
    logic [3:0]  req_fn [2];
    logic [1:0]  rsp_rdy;
    logic        rand_rdy;
    logic [1:0]  rdy_w;
    logic [1:0]  rspv_w;
    alu_t        alu_r;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    int   last_grant = 0;
    int   acc_cyc [2];
    int   grant_log[$];
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    alu_arbiter_ctrl_if bus ();

    alu_arbiter_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req0_valid = req_valid[0];
    assign bus.req0_a     = req_a[0];
    assign bus.req0_b     = req_b[0];
    assign bus.req0_fn    = req_fn[0];
    assign bus.req1_valid = req_valid[1];
    assign bus.req1_a     = req_a[1];
    assign bus.req1_b     = req_b[1];
    assign bus.req1_fn    = req_fn[1];
    assign bus.rsp0_ready = rsp_rdy[0];
    assign bus.rsp1_ready = rsp_rdy[1];
    assign rdy_w  = {bus.req1_ready, bus.req0_ready};
    assign rspv_w = {bus.rsp1_valid, bus.rsp0_valid};

    // External ALU; unsupported codes deliberately produce junk so any leak shows.
    function automatic alu_t alu_calc(input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] fn);
        alu_t        r;
        logic [16:0] w;
        logic [31:0] p;
        r = '0;
        w = '0;
        p = '0;
        case (fn)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r.d = w[15:0];
                r.c = w[16];
                r.v = (a[15] == b[15]) && (r.d[15] != a[15]);
            end
            4'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r.d = w[15:0];
                r.c = w[16];
                r.v = (a[15] != b[15]) && (r.d[15] != a[15]);
            end
            4'd2: begin
                p = {16'h0000, a} * {16'h0000, b};
                r.d = p[15:0];
                r.c = |p[31:16];
            end
            4'd3: r.d = (b == 16'h0000) ? 16'h0000 : a / b;
            default: begin
                r.d = a ^ b ^ 16'h5A5A;
                r.c = 1'b1;
                r.v = 1'b1;
            end
        endcase
        r.z = (r.d == 16'h0000);
        r.n = r.d[15];
        if (fn > 4'd3) begin
            r.z = 1'b1;
            r.n = 1'b1;
        end
        return r;
    endfunction

    always_comb alu_r = alu_calc(bus.alu_a, bus.alu_b, bus.alu_fn);
    assign bus.alu_d_out = alu_r.d;
    assign bus.alu_z     = alu_r.z;
    assign bus.alu_c     = alu_r.c;
    assign bus.alu_n     = alu_r.n;
    assign bus.alu_v     = alu_r.v;

    function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] fn);
        exp_t e;
        alu_t r;
        if (fn > 4'd3) begin
            e.data = 16'h0000; e.flags = 4'b0000; e.err = 1'b1;
        end else if (fn == FN_DIV && b == 16'h0000) begin
            e.data = 16'hFFFF; e.flags = 4'b0000; e.err = 1'b1;
        end else begin
            r = alu_calc(a, b, fn);
            e.data = r.d; e.flags = {r.z, r.c, r.n, r.v}; e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] fn);
        bit got;
        req_a[p] = a;
        req_b[p] = b;
        req_fn[p] = fn;
        req_valid[p] = 1'b1;
        if (p == 0) exp_q0.push_back(ref_model(a, b, fn));
        else        exp_q1.push_back(ref_model(a, b, fn));
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = rdy_w[p];
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: port%0d never saw ready, expected a grant", p);
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !bus.busy;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d/%0d busy=%0b, expected none",
                     exp_q0.size(), exp_q1.size(), bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_port(input int p, input int n);
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fn;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            a  = 16'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                             : 4'($urandom_range(0, 3));
            drive(p, a, b, fn);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) rsp_rdy = 2'($urandom_range(0, 3));
    end

    // Monitor: arbitration model, latency, stability and scoreboard pops.
    initial begin
        logic [1:0] prev_v;
        bit         idle_chk;
        exp_t       held;
        exp_t       cur;
        exp_t       e;
        int         p;
        int         expw;
        prev_v = 2'b00;
        idle_chk = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_ptr = 0;
                prev_v = 2'b00;
                idle_chk = 1'b0;
            end else begin
                if (idle_chk) begin
                    chk("idle_after_hs", 32'(bus.busy), 32'd0);
                    idle_chk = 1'b0;
                end
                if (rdy_w != 2'b00) begin
                    chk("ready_onehot", 32'(rdy_w == 2'b11), 32'd0);
                    chk("ready_only_idle", 32'(bus.busy), 32'd0);
                    p = rdy_w[1] ? 1 : 0;
                    if (req_valid == 2'b11)      expw = model_ptr;
                    else if (req_valid == 2'b10) expw = 1;
                    else if (req_valid == 2'b01) expw = 0;
                    else                         expw = 2;
                    chk("arb_winner", 32'(p), 32'(expw));
                    model_ptr = 1 - p;
                    last_grant = p;
                    acc_cyc[p] = cyc;
                    grant_log.push_back(p);
                end
                if (rspv_w != 2'b00) chk("rsp_onehot", 32'(rspv_w == 2'b11), 32'd0);
                for (int q = 0; q < 2; q++) begin
                    if (rspv_w[q]) begin
                        cur.data = bus.rsp_data;
                        cur.flags = bus.rsp_flags;
                        cur.err = bus.rsp_err;
                        if (!prev_v[q]) begin
                            chk("rsp_port", 32'(q), 32'(last_grant));
                            chk("rsp_latency", 32'(cyc - acc_cyc[q]), 32'd2);
                        end else begin
                            chk("rsp_stable", 32'(cur), 32'(held));
                        end
                        held = cur;
                        if (rsp_rdy[q]) begin
                            if ((q == 0 && exp_q0.size() == 0) || (q == 1 && exp_q1.size() == 0)) begin
                                n_chk++;
                                n_fail++;
                                $display("FAIL rsp_unexpected: port%0d data=0x%0h, expected no response",
                                         q, cur.data);
                            end else begin
                                e = (q == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                                chk("rsp_data", 32'(cur.data), 32'(e.data));
                                chk("rsp_flags", 32'(cur.flags), 32'(e.flags));
                                chk("rsp_err", 32'(cur.err), 32'(e.err));
                            end
                            idle_chk = 1'b1;
                        end
                    end
                end
                prev_v = rspv_w & ~rsp_rdy;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 16'h0;
            req_b[i] = 16'h0;
            req_fn[i] = 4'h0;
        end
        rsp_rdy = 2'b11;
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(rdy_w), 32'd0);
        chk("rst_rsp_valid", 32'(rspv_w), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_alu_fn", 32'(bus.alu_fn), 32'd0);

        // Both requesters valid on the first cycle out of reset
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            drive(0, 16'h0003, 16'h0004, FN_ADD);
            drive(1, 16'hFFFF, 16'h0001, FN_ADD);
        join
        drain();
        chk("order_first", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);
        chk("order_second", 32'(grant_log.size() > 1 ? grant_log[1] : 9), 32'd1);

        drive(0, 16'h0005, 16'h0000, FN_DIV);
        drive(0, 16'h1234, 16'h0002, 4'b0111);
        drive(1, 16'h0064, 16'h0007, FN_DIV);
        drive(1, 16'h0100, 16'h0100, FN_MUL);
        drain();

        // Response back-pressure on port 0 while port 1 waits
        rsp_rdy[0] = 1'b0;
        fork
            drive(0, 16'h1234, 16'h0011, FN_SUB);
            begin
                @(posedge clk);
                #1;
                drive(1, 16'h0002, 16'h0003, FN_SUB);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = rspv_w[0];
                end
                if (!seen) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stall_rsp_timeout: rsp0_valid low, expected high");
                end
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_req1_ready", 32'(bus.req1_ready), 32'd0);
                    chk("stall_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
                end
                @(posedge clk);
                #1;
                rsp_rdy[0] = 1'b1;
            end
        join
        drain();

        // Reset while an operation is in EXEC: it must vanish without a response
        req_a[0] = 16'h0042;
        req_b[0] = 16'h0001;
        req_fn[0] = FN_ADD;
        req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = rdy_w[0];
        end
        chk("rst_test_accept", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rspv_w), 32'd0);
        chk("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rspv_w), 32'd0);
        end
        @(posedge clk);
        #1;
        drive(0, 16'h0010, 16'h0020, FN_ADD);
        drain();

        rand_rdy = 1'b1;
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        rand_rdy = 1'b0;
        rsp_rdy = 2'b11;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
